// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash emulator serving JEDEC ID, status and fast read from a req/gnt/rvalid memory port
module spi_flash_responder #(
   parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        spi_sck_i,
   input  logic        spi_csn_i,
   input  logic        spi_mosi_i,
   output logic        spi_miso_o,
   output logic        spi_miso_oe_o,
   output logic        mem_req_o,
   output logic [23:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [7:0]  mem_rdata_i,
   output logic        cmd_err_o,
   output logic        underrun_o,
   output logic        busy_o
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ID, STATUS, IGNORE} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
   logic sck_s, csn_s, mosi_s, sck_q, csn_q, rise, fall;
   logic [4:0] cnt;
   logic [22:0] sr;
   logic [23:0] bit_in, out_sr, addr;
   logic [7:0] pbuf, val;
   logic pbuf_vld, bnd, want, wait_rv, stale, resolving, good_rv, have, boundary, kill;
   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign csn_s     = csn_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign rise      = sck_s & ~sck_q;
   assign fall      = ~sck_s & sck_q;
   assign busy_o    = ~csn_s;
   assign bit_in    = {sr, mosi_s};
   assign resolving = wait_rv & mem_rvalid_i;
   assign good_rv   = resolving & ~stale;
   assign have      = pbuf_vld | good_rv;
   assign val       = pbuf_vld ? pbuf : (good_rv ? mem_rdata_i : 8'hFF);
   assign boundary  = (state == DATA) & fall & bnd;
   assign kill      = csn_s | (boundary & ~have);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_sync      <= '0;
         csn_sync      <= '1;
         mosi_sync     <= '0;
         sck_q         <= 1'b0;
         csn_q         <= 1'b1;
         state         <= IDLE;
         cnt           <= '0;
         sr            <= '0;
         out_sr        <= '0;
         addr          <= '0;
         pbuf          <= '0;
         pbuf_vld      <= 1'b0;
         bnd           <= 1'b0;
         want          <= 1'b0;
         wait_rv       <= 1'b0;
         stale         <= 1'b0;
         spi_miso_o    <= 1'b0;
         spi_miso_oe_o <= 1'b0;
         mem_req_o     <= 1'b0;
         mem_addr_o    <= '0;
         cmd_err_o     <= 1'b0;
         underrun_o    <= 1'b0;
      end else begin
         sck_sync   <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
         csn_sync   <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
         mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         sck_q      <= sck_s;
         csn_q      <= csn_s;
         cmd_err_o  <= 1'b0;
         underrun_o <= 1'b0;
         if (mem_req_o && mem_gnt_i) begin
            mem_req_o <= 1'b0;
            wait_rv   <= 1'b1;
         end
         if (resolving) wait_rv <= 1'b0;
         stale <= kill ? (mem_req_o | wait_rv) & ~resolving : stale & ~resolving;
         if (good_rv) begin
            pbuf     <= mem_rdata_i;
            pbuf_vld <= 1'b1;
         end
         if (want && !mem_req_o && !wait_rv && !csn_s && !boundary) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= addr;
            want       <= 1'b0;
         end
         if (csn_s) begin
            state         <= IDLE;
            spi_miso_oe_o <= 1'b0;
            spi_miso_o    <= 1'b0;
            cnt           <= '0;
            bnd           <= 1'b0;
            want          <= 1'b0;
            pbuf_vld      <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= csn_q ? CMD : IDLE;
               CMD: if (rise) begin
                  sr  <= bit_in[22:0];
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd7) begin
                     cnt <= '0;
                     if (bit_in[7:0] == 8'h0B) state <= ADDR;
                     else if (bit_in[7:0] == 8'h9F) begin
                        state  <= ID;
                        out_sr <= JEDEC_ID;
                     end else if (bit_in[7:0] == 8'h05) begin
                        state  <= STATUS;
                        out_sr <= '0;
                     end else begin
                        state     <= IGNORE;
                        cmd_err_o <= 1'b1;
                     end
                  end
               end
               ADDR: if (rise) begin
                  sr  <= bit_in[22:0];
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd23) begin
                     cnt   <= '0;
                     addr  <= bit_in;
                     want  <= 1'b1;
                     state <= DUMMY;
                  end
               end
               DUMMY: if (rise) begin
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd7) begin
                     cnt   <= '0;
                     bnd   <= 1'b1;
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (rise) begin
                     cnt <= cnt + 5'd1;
                     if (cnt == 5'd7) begin
                        cnt <= '0;
                        bnd <= 1'b1;
                     end
                  end
                  if (boundary) begin
                     spi_miso_oe_o <= 1'b1;
                     spi_miso_o    <= val[7];
                     out_sr        <= {val[6:0], 17'h0};
                     bnd           <= 1'b0;
                     pbuf_vld      <= 1'b0;
                     addr          <= addr + 24'd1;
                     want          <= 1'b1;
                     underrun_o    <= ~have;
                  end else if (fall) begin
                     spi_miso_o <= out_sr[23];
                     out_sr     <= {out_sr[22:0], out_sr[23]};
                  end
               end
               ID, STATUS: if (fall) begin
                  spi_miso_oe_o <= 1'b1;
                  spi_miso_o    <= out_sr[23];
                  out_sr        <= {out_sr[22:0], out_sr[23]};
               end
               default: ;
            endcase
         end
      end
   end
endmodule
